// File: rtl/condicionador_botoes_if.sv
// Button-conditioner bus: raw pins and enable in, conditioned pulses and levels out.
interface condicionador_botoes_if #(
  parameter int N_BOTOES = 8
);
  logic [N_BOTOES-1:0] botoes_raw;
  logic                habilita;
  logic [N_BOTOES-1:0] pulsos;
  logic [N_BOTOES-1:0] pressionados;
  logic                algum;

  modport master (
    output botoes_raw,
    output habilita,
    input  pulsos,
    input  pressionados,
    input  algum
  );

  modport slave (
    input  botoes_raw,
    input  habilita,
    output pulsos,
    output pressionados,
    output algum
  );
endinterface

// File: rtl/condicionador_botoes.sv
// Button conditioner: per-channel 2-FF sync, counter debounce, press-edge pulse, enable gate.
// Optional macro CONDICIONADOR_BOTOES_EXCLUSIVO_EN keeps pulsos one-hot (lowest index wins).
module condicionador_botoes #(
  parameter int N_BOTOES        = 8,
  parameter int DEBOUNCE_CICLOS = 50000,
  parameter int CNT_W           = 16,
  parameter int ATIVO_BAIXO     = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  condicionador_botoes_if.slave  bus
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CICLOS - 1);

  logic [N_BOTOES-1:0] pressed;
  logic [N_BOTOES-1:0] s1_p0;
  logic [N_BOTOES-1:0] s2_p1;
  logic [N_BOTOES-1:0] estavel;
  logic [N_BOTOES-1:0] estavel_next;
  logic [N_BOTOES-1:0] rise;
  logic [N_BOTOES-1:0] pulse_cand;
  logic [N_BOTOES-1:0] pulse_next;
  logic [N_BOTOES-1:0] pulsos_q;
  logic                algum_q;
  logic [CNT_W-1:0]    cnt      [N_BOTOES];
  logic [CNT_W-1:0]    cnt_next [N_BOTOES];

  // Normalise to active-high before synchronising so all internal state means "pressed".
  assign pressed = (ATIVO_BAIXO != 0) ? ~bus.botoes_raw : bus.botoes_raw;

  // Debounce: a level is accepted only after DEBOUNCE_CICLOS consecutive differing samples.
  always_comb begin
    estavel_next = estavel;
    rise         = '0;
    for (int i = 0; i < N_BOTOES; i++) begin
      cnt_next[i] = cnt[i];
      if (s2_p1[i] == estavel[i]) begin
        cnt_next[i] = '0;
      end else if (cnt[i] == CNT_MAX) begin
        estavel_next[i] = s2_p1[i];
        cnt_next[i]     = '0;
        rise[i]         = s2_p1[i];
      end else begin
        cnt_next[i] = cnt[i] + CNT_W'(1);
      end
    end
  end

  assign pulse_cand = rise & {N_BOTOES{bus.habilita}};

`ifdef CONDICIONADOR_BOTOES_EXCLUSIVO_EN
  // Isolate the lowest set bit; dropped channels still update estavel above.
  assign pulse_next = pulse_cand & (~pulse_cand + N_BOTOES'(1));
`else
  assign pulse_next = pulse_cand;
`endif

  // Stage p0/p1: synchroniser; then debounce state and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_p0    <= '0;
      s2_p1    <= '0;
      estavel  <= '0;
      pulsos_q <= '0;
      algum_q  <= 1'b0;
      for (int i = 0; i < N_BOTOES; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      s1_p0    <= pressed;
      s2_p1    <= s1_p0;
      estavel  <= estavel_next;
      pulsos_q <= pulse_next;
      algum_q  <= |estavel_next;
      for (int i = 0; i < N_BOTOES; i++) begin
        cnt[i] <= cnt_next[i];
      end
    end
  end

  assign bus.pulsos       = pulsos_q;
  assign bus.pressionados = estavel;
  assign bus.algum        = algum_q;

endmodule

// File: tb/tb_condicionador_botoes.sv
// Bench for condicionador_botoes: expected pulses queued at stimulus time, checked every cycle.
module tb_condicionador_botoes;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  bit   mon_en = 1'b0;

  typedef struct {
    int         cyc;
    logic [7:0] val;
  } exp_t;

  exp_t q[$];
  exp_t e;

  condicionador_botoes_if #(.N_BOTOES(8)) ifc ();

  condicionador_botoes #(
    .N_BOTOES       (8),
    .DEBOUNCE_CICLOS(4),
    .CNT_W          (16),
    .ATIVO_BAIXO    (1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(ifc.slave)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard monitor: every cycle pulsos must equal the queued value or zero.
  always @(negedge clk) begin
    if (mon_en) begin
      if (q.size() > 0 && q[0].cyc == cyc) begin
        e = q.pop_front();
        total++;
        if (ifc.pulsos !== e.val) begin
          bad++;
          $display("FAIL pulse_sb cyc=%0d got=%h exp=%h", cyc, ifc.pulsos, e.val);
        end
      end else begin
        total++;
        if (ifc.pulsos !== 8'h00) begin
          bad++;
          $display("FAIL idle_pulse cyc=%0d got=%h exp=00", cyc, ifc.pulsos);
        end
      end
    end
  end

  task automatic wait_neg(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push_exp(input int at, input logic [7:0] val);
    exp_t x;
    x.cyc = at;
    x.val = val;
    q.push_back(x);
  endtask

  task automatic check_levels(input string name, input logic [7:0] pr, input logic al);
    total++;
    if (ifc.pressionados !== pr || ifc.algum !== al) begin
      bad++;
      $display("FAIL %s cyc=%0d pressionados=%h algum=%b exp=%h/%b",
               name, cyc, ifc.pressionados, ifc.algum, pr, al);
    end
  endtask

  task automatic test_reset();
    ifc.botoes_raw = 8'h00;
    ifc.habilita   = 1'b1;
    #1 rst = 1'b0;
    #1 mon_en = 1'b1;
    wait_neg(3);
    total++;
    if (ifc.pulsos !== 8'h00) begin
      bad++;
      $display("FAIL reset_pulsos got=%h exp=00", ifc.pulsos);
    end
    check_levels("reset_levels", 8'h00, 1'b0);
    ifc.botoes_raw = 8'hFF;
    rst = 1'b1;
    wait_neg(20);
    check_levels("reset_idle", 8'h00, 1'b0);
  endtask

  task automatic test_clean_press();
    int c;
    @(negedge clk);
    c = cyc;
    ifc.botoes_raw = 8'hFE;
    push_exp(c + 6, 8'h01);
    wait_neg(5);
    check_levels("press_before", 8'h00, 1'b0);
    wait_neg(1);
    check_levels("press_accept", 8'h01, 1'b1);
    wait_neg(50);
    check_levels("press_hold", 8'h01, 1'b1);
    c = cyc;
    ifc.botoes_raw = 8'hFF;
    wait_neg(5);
    check_levels("release_before", 8'h01, 1'b1);
    wait_neg(1);
    check_levels("release_accept", 8'h00, 1'b0);
    wait_neg(5);
  endtask

  task automatic test_bounce();
    for (int k = 0; k < 10; k++) begin
      ifc.botoes_raw = 8'hF7;
      wait_neg(1);
      ifc.botoes_raw = 8'hFF;
      wait_neg(1);
    end
    check_levels("bounce_settle", 8'h00, 1'b0);
    ifc.botoes_raw = 8'hF7;
    push_exp(cyc + 6, 8'h08);
    wait_neg(6);
    check_levels("bounce_accept", 8'h08, 1'b1);
    ifc.botoes_raw = 8'hFF;
    wait_neg(10);
    check_levels("bounce_release", 8'h00, 1'b0);
  endtask

  task automatic test_enable_gate();
    ifc.habilita   = 1'b0;
    ifc.botoes_raw = 8'hFB;
    wait_neg(8);
    check_levels("gate_level", 8'h04, 1'b1);
    ifc.habilita = 1'b1;
    wait_neg(10);
    check_levels("gate_held", 8'h04, 1'b1);
    ifc.botoes_raw = 8'hFF;
    wait_neg(8);
    check_levels("gate_release", 8'h00, 1'b0);
  endtask

  task automatic test_simultaneous();
    ifc.botoes_raw = 8'hDD;
`ifdef CONDICIONADOR_BOTOES_EXCLUSIVO_EN
    push_exp(cyc + 6, 8'h02);
`else
    push_exp(cyc + 6, 8'h22);
`endif
    wait_neg(6);
    check_levels("simul_levels", 8'h22, 1'b1);
    ifc.botoes_raw = 8'hFF;
    wait_neg(10);
    check_levels("simul_release", 8'h00, 1'b0);
  endtask

  task automatic test_async_reset();
    ifc.botoes_raw = 8'h7F;
    wait_neg(3);
    rst = 1'b0;
    #1;
    total++;
    if (ifc.pulsos !== 8'h00) begin
      bad++;
      $display("FAIL areset_pulsos got=%h exp=00", ifc.pulsos);
    end
    check_levels("areset_levels", 8'h00, 1'b0);
    wait_neg(2);
    rst = 1'b1;
    push_exp(cyc + 6, 8'h80);
    wait_neg(5);
    check_levels("areset_before", 8'h00, 1'b0);
    wait_neg(1);
    check_levels("areset_accept", 8'h80, 1'b1);
    ifc.botoes_raw = 8'hFF;
    wait_neg(10);
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_bounce();
    test_enable_gate();
    test_simultaneous();
    test_async_reset();
    for (int k = 0; k < 20 && q.size() > 0; k++) wait_neg(1);
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL sb_drain pending=%0d exp=0", q.size());
    end
    mon_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
